// File: rtl/bp_cce_inv_cmd_tx.sv
// Serialises one invalidate per sharing LCE onto the LCE command channel and
// counts inv_acks until all are returned. Optional: BP_CCE_INV_SKIP_REQ_EN masks the requestor.
module bp_cce_inv_cmd_tx #(
    parameter int num_lce_p         = 4,
    parameter int lce_id_width_p    = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
    parameter int lce_assoc_p       = 8,
    parameter int lce_assoc_width_p = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
    parameter int paddr_width_p     = 40
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   start_v_i,
    output logic                                   ready_o,
    input  logic [paddr_width_p-1:0]               paddr_i,
    input  logic [lce_id_width_p-1:0]              req_lce_id_i,
    input  logic [num_lce_p-1:0]                   sharers_i,
    input  logic [num_lce_p*lce_assoc_width_p-1:0] sharer_ways_i,
    output logic                                   cmd_v_o,
    input  logic                                   cmd_ready_i,
    output logic [lce_id_width_p-1:0]              cmd_dst_id_o,
    output logic [paddr_width_p-1:0]               cmd_addr_o,
    output logic [lce_assoc_width_p-1:0]           cmd_way_o,
    input  logic                                   ack_v_i,
    output logic                                   done_v_o,
    input  logic                                   done_yumi_i,
    output logic                                   err_o
);

    localparam int cnt_width_lp = $clog2(num_lce_p + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;

    state_e                                 state_r, state_n;
    logic [num_lce_p-1:0]                   pend_r, pend_n, start_mask;
    logic [cnt_width_lp-1:0]                sent_r, sent_n, ack_r, ack_n;
    logic                                   err_r, err_n;
    logic [paddr_width_p-1:0]               paddr_r;
    logic [num_lce_p*lce_assoc_width_p-1:0] ways_r;
    logic [lce_id_width_p-1:0]              low_idx;
    logic                                   ready, cmd_v, done_v, start_fire, send_fire;

`ifdef BP_CCE_INV_SKIP_REQ_EN
    assign start_mask = sharers_i & ~(num_lce_p'(1) << req_lce_id_i);
`else
    logic unused_req;
    assign unused_req = ^req_lce_id_i;
    assign start_mask = sharers_i;
`endif

    always_comb begin
        low_idx = '0;
        for (int i = num_lce_p - 1; i >= 0; i--) begin
            if (pend_r[i]) low_idx = lce_id_width_p'(i);
        end
    end

    assign start_fire = (state_r == IDLE) && start_v_i;
    assign send_fire  = (state_r == SEND) && cmd_ready_i;

    always_comb begin
        state_n = state_r;
        pend_n  = pend_r;
        sent_n  = sent_r;
        ack_n   = ack_r;
        err_n   = err_r;
        ready   = 1'b0;
        cmd_v   = 1'b0;
        done_v  = 1'b0;

        case (state_r)
            IDLE: begin
                ready = 1'b1;
                if (start_fire) begin
                    pend_n  = start_mask;
                    sent_n  = '0;
                    ack_n   = '0;
                    err_n   = 1'b0;
                    state_n = (start_mask == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                cmd_v = 1'b1;
                if (send_fire) begin
                    pend_n[low_idx] = 1'b0;
                    sent_n          = sent_r + cnt_width_lp'(1);
                end
            end
            WAIT: ;
            DONE: begin
                done_v = 1'b1;
                if (done_yumi_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // An ack only counts while a command it could answer has been sent,
        // including one handshaking in this same cycle.
        if (ack_v_i) begin
            if ((state_r == SEND || state_r == WAIT) && (ack_r < sent_n)) begin
                ack_n = ack_r + cnt_width_lp'(1);
            end else begin
                err_n = 1'b1;
            end
        end

        if (state_r == SEND && send_fire && pend_n == '0) begin
            state_n = (ack_n == sent_n) ? DONE : WAIT;
        end else if (state_r == WAIT && ack_n == sent_n) begin
            state_n = DONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            pend_r  <= '0;
            sent_r  <= '0;
            ack_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            pend_r  <= pend_n;
            sent_r  <= sent_n;
            ack_r   <= ack_n;
            err_r   <= err_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (start_fire) begin
            paddr_r <= paddr_i;
            ways_r  <= sharer_ways_i;
        end
    end

    // Data fields are forced to zero whenever no command is offered.
    assign ready_o      = ready & reset_n_i;
    assign cmd_v_o      = cmd_v & reset_n_i;
    assign done_v_o     = done_v & reset_n_i;
    assign err_o        = err_r & reset_n_i;
    assign cmd_dst_id_o = cmd_v_o ? low_idx : '0;
    assign cmd_addr_o   = cmd_v_o ? paddr_r : '0;
    assign cmd_way_o    = cmd_v_o ? ways_r[low_idx*lce_assoc_width_p +: lce_assoc_width_p] : '0;

endmodule

// File: tb/tb_bp_cce_inv_cmd_tx.sv
// Directed self-checking bench for bp_cce_inv_cmd_tx (num_lce_p=4, 8-way, 40-bit paddr).
module tb_bp_cce_inv_cmd_tx;

    localparam int NL = 4;
    localparam int IW = 2;
    localparam int WW = 3;
    localparam int PW = 40;

    logic          clk = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          start_v_i = 1'b0;
    logic          ready_o;
    logic [PW-1:0] paddr_i = '0;
    logic [IW-1:0] req_lce_id_i = '0;
    logic [NL-1:0] sharers_i = '0;
    logic [NL*WW-1:0] sharer_ways_i = '0;
    logic          cmd_v_o;
    logic          cmd_ready_i = 1'b0;
    logic [IW-1:0] cmd_dst_id_o;
    logic [PW-1:0] cmd_addr_o;
    logic [WW-1:0] cmd_way_o;
    logic          ack_v_i = 1'b0;
    logic          done_v_o;
    logic          done_yumi_i = 1'b0;
    logic          err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;

    bp_cce_inv_cmd_tx dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .start_v_i(start_v_i), .ready_o(ready_o),
        .paddr_i(paddr_i), .req_lce_id_i(req_lce_id_i), .sharers_i(sharers_i),
        .sharer_ways_i(sharer_ways_i), .cmd_v_o(cmd_v_o), .cmd_ready_i(cmd_ready_i),
        .cmd_dst_id_o(cmd_dst_id_o), .cmd_addr_o(cmd_addr_o), .cmd_way_o(cmd_way_o),
        .ack_v_i(ack_v_i), .done_v_o(done_v_o), .done_yumi_i(done_yumi_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cmd_v_o && cmd_ready_i) hs_cnt <= hs_cnt + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd_chk(input string tag, input logic [IW-1:0] dst, input logic [WW-1:0] way,
                           input logic [PW-1:0] addr);
        check_eq({tag, "_v"}, 64'(cmd_v_o), 64'd1);
        check_eq({tag, "_dst"}, 64'(cmd_dst_id_o), 64'(dst));
        check_eq({tag, "_way"}, 64'(cmd_way_o), 64'(way));
        check_eq({tag, "_addr"}, 64'(cmd_addr_o), 64'(addr));
    endtask

    task automatic retire();
        done_yumi_i = 1'b1;
        tick();
        done_yumi_i = 1'b0;
        check_eq("ready_after_yumi", 64'(ready_o), 64'd1);
        check_eq("done_after_yumi", 64'(done_v_o), 64'd0);
    endtask

    initial begin
        // Reset held with start asserted
        start_v_i = 1'b1;
        sharers_i = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_ready", 64'(ready_o), 64'd0);
            check_eq("rst_cmd_v", 64'(cmd_v_o), 64'd0);
            check_eq("rst_done", 64'(done_v_o), 64'd0);
            check_eq("rst_err", 64'(err_o), 64'd0);
            check_eq("rst_addr", 64'(cmd_addr_o), 64'd0);
        end
        start_v_i = 1'b0;
        reset_n_i = 1'b1;
        tick();
        check_eq("post_rst_ready", 64'(ready_o), 64'd1);
        check_eq("post_rst_cmd_v", 64'(cmd_v_o), 64'd0);
        check_eq("post_rst_done", 64'(done_v_o), 64'd0);

        // Three sharers, acks two cycles after each command
        paddr_i       = 40'h12_3456_7890;
        req_lce_id_i  = 2'd2;
        sharers_i     = 4'b1011;
        sharer_ways_i = {3'd1, 3'd7, 3'd3, 3'd5};
        cmd_ready_i   = 1'b1;
        start_v_i     = 1'b1;
        hs_cnt        = 0;
        tick();
        start_v_i = 1'b0;
        paddr_i   = '0;
        cmd_chk("t2_c0", 2'd0, 3'd5, 40'h12_3456_7890);
        tick();
        cmd_chk("t2_c1", 2'd1, 3'd3, 40'h12_3456_7890);
        tick();
        cmd_chk("t2_c2", 2'd3, 3'd1, 40'h12_3456_7890);
        ack_v_i = 1'b1;
        tick();
        cmd_ready_i = 1'b0;
        check_eq("t2_wait_cmd_v", 64'(cmd_v_o), 64'd0);
        check_eq("t2_wait_done1", 64'(done_v_o), 64'd0);
        check_eq("t2_hs", 64'(hs_cnt), 64'd3);
        tick();
        check_eq("t2_wait_done2", 64'(done_v_o), 64'd0);
        tick();
        ack_v_i = 1'b0;
        check_eq("t2_done", 64'(done_v_o), 64'd1);
        check_eq("t2_err", 64'(err_o), 64'd0);
        tick();
        check_eq("t2_done_hold", 64'(done_v_o), 64'd1);
        retire();

        // Sole sharer is the requestor
        req_lce_id_i  = 2'd2;
        sharers_i     = 4'b0100;
        sharer_ways_i = {3'd0, 3'd7, 3'd0, 3'd0};
        paddr_i       = 40'h00_0000_0040;
        start_v_i     = 1'b1;
        tick();
        start_v_i = 1'b0;
`ifdef BP_CCE_INV_SKIP_REQ_EN
        check_eq("t3_done_t1", 64'(done_v_o), 64'd1);
        check_eq("t3_no_cmd", 64'(cmd_v_o), 64'd0);
`else
        cmd_chk("t3_c0", 2'd2, 3'd7, 40'h00_0000_0040);
        cmd_ready_i = 1'b1;
        tick();
        cmd_ready_i = 1'b0;
        check_eq("t3_wait_cmd_v", 64'(cmd_v_o), 64'd0);
        check_eq("t3_wait_done", 64'(done_v_o), 64'd0);
        ack_v_i = 1'b1;
        tick();
        ack_v_i = 1'b0;
        check_eq("t3_done", 64'(done_v_o), 64'd1);
`endif
        retire();

        // Backpressure toggling 0/1/0/1
        req_lce_id_i  = 2'd0;
        sharers_i     = 4'b0110;
        sharer_ways_i = {3'd0, 3'd6, 3'd2, 3'd0};
        paddr_i       = 40'hAB_CDEF_0123;
        cmd_ready_i   = 1'b0;
        start_v_i     = 1'b1;
        hs_cnt        = 0;
        tick();
        start_v_i = 1'b0;
        paddr_i   = 40'h11_1111_1111;
        cmd_chk("t4_c0", 2'd1, 3'd2, 40'hAB_CDEF_0123);
        tick();
        cmd_chk("t4_c0_stall", 2'd1, 3'd2, 40'hAB_CDEF_0123);
        cmd_ready_i = 1'b1;
        tick();
        cmd_ready_i = 1'b0;
        cmd_chk("t4_c1", 2'd2, 3'd6, 40'hAB_CDEF_0123);
        tick();
        cmd_chk("t4_c1_stall", 2'd2, 3'd6, 40'hAB_CDEF_0123);
        cmd_ready_i = 1'b1;
        tick();
        cmd_ready_i = 1'b0;
        check_eq("t4_wait_cmd_v", 64'(cmd_v_o), 64'd0);
        tick();
        check_eq("t4_no_ack_done", 64'(done_v_o), 64'd0);
        ack_v_i = 1'b1;
        tick();
        check_eq("t4_one_ack_done", 64'(done_v_o), 64'd0);
        tick();
        ack_v_i = 1'b0;
        check_eq("t4_done", 64'(done_v_o), 64'd1);
        check_eq("t4_hs", 64'(hs_cnt), 64'd2);
        retire();

        // Ack for cmd 0 lands with the cmd 1 handshake
        req_lce_id_i  = 2'd3;
        sharers_i     = 4'b0011;
        sharer_ways_i = {3'd0, 3'd0, 3'd1, 3'd4};
        paddr_i       = 40'h00_DEAD_BEE0;
        cmd_ready_i   = 1'b1;
        start_v_i     = 1'b1;
        tick();
        start_v_i = 1'b0;
        cmd_chk("t5_c0", 2'd0, 3'd4, 40'h00_DEAD_BEE0);
        tick();
        cmd_chk("t5_c1", 2'd1, 3'd1, 40'h00_DEAD_BEE0);
        ack_v_i = 1'b1;
        tick();
        ack_v_i     = 1'b0;
        cmd_ready_i = 1'b0;
        check_eq("t5_ack_cnt", 64'(dut.ack_r), 64'd1);
        check_eq("t5_sent_cnt", 64'(dut.sent_r), 64'd2);
        check_eq("t5_not_done", 64'(done_v_o), 64'd0);
        ack_v_i = 1'b1;
        tick();
        ack_v_i = 1'b0;
        check_eq("t5_done", 64'(done_v_o), 64'd1);
        check_eq("t5_err", 64'(err_o), 64'd0);
        retire();

        // Spurious acks: in IDLE, then an extra one in DONE
        ack_v_i = 1'b1;
        tick();
        ack_v_i = 1'b0;
        check_eq("t6_idle_err", 64'(err_o), 64'd1);
        tick();
        check_eq("t6_err_sticky", 64'(err_o), 64'd1);
        req_lce_id_i  = 2'd2;
        sharers_i     = 4'b1011;
        sharer_ways_i = {3'd1, 3'd7, 3'd3, 3'd5};
        paddr_i       = 40'h00_0000_1000;
        cmd_ready_i   = 1'b1;
        start_v_i     = 1'b1;
        tick();
        start_v_i = 1'b0;
        check_eq("t6_start_clears_err", 64'(err_o), 64'd0);
        ack_v_i = 1'b1;
        tick();
        tick();
        tick();
        cmd_ready_i = 1'b0;
        check_eq("t6_min_lat_done", 64'(done_v_o), 64'd1);
        check_eq("t6_err_clean", 64'(err_o), 64'd0);
        tick();
        ack_v_i = 1'b0;
        check_eq("t6_extra_ack_err", 64'(err_o), 64'd1);
        check_eq("t6_ack_capped", 64'(dut.ack_r), 64'd3);
        check_eq("t6_done_hold", 64'(done_v_o), 64'd1);
        retire();
        check_eq("t6_err_sticky_idle", 64'(err_o), 64'd1);

        // Ack before any send in SEND is rejected
        sharers_i   = 4'b0001;
        cmd_ready_i = 1'b0;
        start_v_i   = 1'b1;
        tick();
        start_v_i = 1'b0;
        check_eq("t7_err_cleared", 64'(err_o), 64'd0);
        ack_v_i = 1'b1;
        tick();
        ack_v_i = 1'b0;
        check_eq("t7_early_ack_err", 64'(err_o), 64'd1);
        check_eq("t7_early_ack_cnt", 64'(dut.ack_r), 64'd0);
        cmd_ready_i = 1'b1;
        tick();
        cmd_ready_i = 1'b0;
        check_eq("t7_wait", 64'(done_v_o), 64'd0);
        ack_v_i = 1'b1;
        tick();
        ack_v_i = 1'b0;
        check_eq("t7_done", 64'(done_v_o), 64'd1);
        check_eq("t7_err_kept", 64'(err_o), 64'd1);
        retire();

        // Zero sharers: done in T+1 with no command
        sharers_i = 4'b0000;
        start_v_i = 1'b1;
        tick();
        start_v_i = 1'b0;
        check_eq("t8_done_t1", 64'(done_v_o), 64'd1);
        check_eq("t8_no_cmd", 64'(cmd_v_o), 64'd0);
        check_eq("t8_err_cleared", 64'(err_o), 64'd0);
        retire();

        // Reset mid-operation aborts the command stream
        sharers_i   = 4'b1111;
        cmd_ready_i = 1'b0;
        start_v_i   = 1'b1;
        tick();
        start_v_i = 1'b0;
        check_eq("t9_cmd_v", 64'(cmd_v_o), 64'd1);
        reset_n_i = 1'b0;
        tick();
        check_eq("t9_rst_cmd_v", 64'(cmd_v_o), 64'd0);
        reset_n_i = 1'b1;
        tick();
        check_eq("t9_ready", 64'(ready_o), 64'd1);
        check_eq("t9_no_cmd", 64'(cmd_v_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
